vote_count_bank: RTL and testbench
==================================

# vote_count_bank

Multi-channel, parametrised successor to the single latency counter: a bank of NUM_CH independent WIDTH-bit counters with per-cycle increment-by-amount, per-channel set, global clear, saturating or wrapping arithmetic, sticky overflow flags, and a pipelined read port with configurable latency. It sits after the tree-evaluation stage of the random-forest classifier. It accumulates per-class votes and continuously publishes the leading class (argmax) to the result stage.

## Interface
- WIDTH, 13: counter width in bits (2..32)
- NUM_CH, 8: number of counters/classes (2..64); CH_W = max(1, $clog2(NUM_CH))
- LAT, 2: read latency in cycles (1..8)
- SATURATE, 1: 1 = clamp at all-ones, 0 = wrap modulo 2^WIDTH

- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  reset, synchronous, active-low
- inc_vld  in  1  apply increment this cycle
- inc_ch  in  CH_W  channel to increment
- inc_amt  in  WIDTH  increment amount (0 legal, no-op on value)
- set_vld  in  1  load set_val this cycle
- set_ch  in  CH_W  channel to load
- set_val  in  WIDTH  value to load
- clear_all  in  1  zero every counter and flag
- rd_vld  in  1  read request
- rd_ch  in  CH_W  channel to read
- rd_data  out  WIDTH  read result
- rd_data_vld  out  1  rd_data valid strobe
- ovf  out  NUM_CH  sticky per-channel overflow flags
- max_ch  out  CH_W  index of largest counter
- max_val  out  WIDTH  value of largest counter

## Operation
- Counters cnt[i] are registers. All updates are single-cycle read-modify-write. No input backpressure; every request is accepted.
- Per-channel next-value priority:
  - !rst_n
  - then clear_all (cnt=0, ovf=0)
  - then set on that channel (cnt=set_val, ovf[i]=0; a same-cycle inc to that channel is dropped)
  - then inc on that channel
  - else hold.
- set and inc on different channels in the same cycle both apply.
- Increment arithmetic is at WIDTH+1 bits: sum = cnt + inc_amt. If sum[WIDTH]=1:
  - SATURATE=1: cnt = all-ones.
  - SATURATE=0: cnt = sum[WIDTH-1:0].
  - In either mode ovf[i] is set and stays set until clear_all, a set on that channel, or reset.
- Channel index >= NUM_CH:
  - inc/set with such an index is ignored (no state change).
  - A read with such an index returns rd_data=0, rd_data_vld=1.
- Read is read-before-write: a request sampled at edge N returns cnt[rd_ch] as held before edge N. Updates accepted at edge N are not included. The result is carried through a LAT-stage pipeline of data plus valid.
- Argmax: a registered comparison over the current counters. Ties resolve to the lowest index. Comparison is unsigned.

## Timing
- Reset: on the first edge with rst_n=0, all of the following are zero:
  - cnt[*] and ovf
  - rd_data and rd_data_vld
  - every read-pipeline stage
  - max_ch and max_val
- Reset mid-operation discards in-flight reads: no rd_data_vld follows reset.
- Updates: an inc/set/clear sampled at edge N is visible in cnt and ovf after edge N. It is visible to a read sampled at edge N+1.
- Read: rd_vld at edge N gives rd_data_vld=1 with data during the cycle after edge N+LAT-1. That is LAT cycles later, with LAT=1 meaning the next cycle.
- Reads are fully pipelined: back-to-back rd_vld yields back-to-back rd_data_vld in order. rd_data holds its last value when rd_data_vld=0.
- Argmax: max_ch/max_val reflect counter state one cycle after that state is registered, i.e. 2 cycles after the update request edge. After clear_all they read 0/0.

## Test plan
- Reset and idle:
  - Stimulus: assert rst_n=0 mid-traffic with 2 reads in flight (LAT=2).
  - Required: all outputs 0; no rd_data_vld afterwards; every counter reads 0.
- Basic accumulate:
  - Stimulus: inc ch3 by 1 for 5 cycles, then inc ch5 by 7.
  - Required: read ch3 returns 5 and read ch5 returns 7, each after exactly LAT cycles; max_ch=5, max_val=7.
- Saturate vs wrap, WIDTH=4:
  - Stimulus: set ch0=14, then inc 3.
  - Required with SATURATE=1: reads 15, ovf[0]=1.
  - Required with SATURATE=0: reads 1, ovf[0]=1.
  - Required after a subsequent set ch0=2: ovf[0]=0.
- Simultaneous events:
  - Stimulus: same cycle set ch2=9 and inc ch2 by 4.
  - Required: ch2 reads 9.
  - Stimulus: same cycle set ch1=9 and inc ch6 by 4.
  - Required: ch1=9 and ch6=4.
  - Stimulus: clear_all together with set.
  - Required: all counters 0.
- Read-before-write and pipelining:
  - Stimulus: ch4=10; inc ch4 by 1 and read ch4 in the same cycle, then read again the next cycle.
  - Required: consecutive rd_data 10 then 11, on consecutive cycles.
- Argmax tie and out-of-range index (NUM_CH=6):
  - Stimulus: ch1=ch4=8.
  - Required: max_ch=1.
  - Stimulus: inc/set to ch7.
  - Required: no state change.
  - Stimulus: read ch7.
  - Required: rd_data=0 with rd_data_vld=1.

Source files
------------

// File: rtl/vote_count_bank.sv
// Bank of per-class vote counters (inc / set / clear, saturate or wrap, sticky
// overflow) with a LAT-stage read pipeline and a registered argmax output.
module vote_count_bank #(
  parameter int WIDTH    = 13,
  parameter int NUM_CH   = 8,
  parameter int LAT      = 2,
  parameter int SATURATE = 1,
  localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              inc_vld,
  input  logic [CH_W-1:0]   inc_ch,
  input  logic [WIDTH-1:0]  inc_amt,
  input  logic              set_vld,
  input  logic [CH_W-1:0]   set_ch,
  input  logic [WIDTH-1:0]  set_val,
  input  logic              clear_all,
  input  logic              rd_vld,
  input  logic [CH_W-1:0]   rd_ch,
  output logic [WIDTH-1:0]  rd_data,
  output logic              rd_data_vld,
  output logic [NUM_CH-1:0] ovf,
  output logic [CH_W-1:0]   max_ch,
  output logic [WIDTH-1:0]  max_val
);

  logic [WIDTH-1:0] w_cnt [NUM_CH];
  logic [WIDTH-1:0] w_rd_data;
  logic [CH_W-1:0]  w_max_ch;
  logic [WIDTH-1:0] w_max_val;
  logic [WIDTH-1:0] r_pipe_data [LAT];
  logic [LAT-1:0]   r_pipe_vld;
  logic [CH_W-1:0]  r_max_ch;
  logic [WIDTH-1:0] r_max_val;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic [WIDTH-1:0] r_cnt;
    logic             r_ovf;
    logic [WIDTH:0]   w_sum;
    logic             w_set_hit;
    logic             w_inc_hit;

    assign w_set_hit = set_vld && (set_ch == CH_W'(g));
    assign w_inc_hit = inc_vld && (inc_ch == CH_W'(g));
    assign w_sum     = {1'b0, r_cnt} + {1'b0, inc_amt};

    // A set on this channel overrides a same-cycle increment to it.
    always_ff @(posedge clk) begin
      if (!rst_n || clear_all) begin
        r_cnt <= '0;
        r_ovf <= 1'b0;
      end else if (w_set_hit) begin
        r_cnt <= set_val;
        r_ovf <= 1'b0;
      end else if (w_inc_hit) begin
        if (w_sum[WIDTH]) begin
          r_cnt <= (SATURATE != 0) ? {WIDTH{1'b1}} : w_sum[WIDTH-1:0];
          r_ovf <= 1'b1;
        end else begin
          r_cnt <= w_sum[WIDTH-1:0];
        end
      end
    end

    assign w_cnt[g] = r_cnt;
    assign ovf[g]   = r_ovf;
  end

  // Out-of-range channels fall through to zero.
  always_comb begin
    w_rd_data = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (rd_ch == CH_W'(i)) w_rd_data = w_cnt[i];
    end
  end

  // Strict greater-than keeps the lowest index on ties.
  always_comb begin
    w_max_ch  = '0;
    w_max_val = w_cnt[0];
    for (int i = 1; i < NUM_CH; i++) begin
      if (w_cnt[i] > w_max_val) begin
        w_max_ch  = CH_W'(i);
        w_max_val = w_cnt[i];
      end
    end
  end

  // Data stages only advance with a valid entry, so the output holds its last value.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pipe_vld <= '0;
      for (int k = 0; k < LAT; k++) r_pipe_data[k] <= '0;
    end else begin
      r_pipe_vld[0] <= rd_vld;
      if (rd_vld) r_pipe_data[0] <= w_rd_data;
      for (int k = 1; k < LAT; k++) begin
        r_pipe_vld[k] <= r_pipe_vld[k-1];
        if (r_pipe_vld[k-1]) r_pipe_data[k] <= r_pipe_data[k-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_max_ch  <= '0;
      r_max_val <= '0;
    end else begin
      r_max_ch  <= w_max_ch;
      r_max_val <= w_max_val;
    end
  end

  assign rd_data     = r_pipe_data[LAT-1];
  assign rd_data_vld = r_pipe_vld[LAT-1];
  assign max_ch      = r_max_ch;
  assign max_val     = r_max_val;

endmodule

// File: tb/tb_vote_count_bank.sv
// Drives three differently parameterised vote_count_bank instances with one
// stimulus stream and checks every output each cycle against an arithmetic model.
module tb_vote_count_bank;

  localparam int ND = 3;

  logic        clk;
  logic        rstN;
  logic        incVld, setVld, clearAll, rdVld;
  logic [2:0]  incCh, setCh, rdCh;
  logic [12:0] incAmt, setVal;

  logic [3:0]  rdDataA, maxValA, rdDataB, maxValB;
  logic [12:0] rdDataC, maxValC;
  logic        rdVldA, rdVldB, rdVldC;
  logic [5:0]  ovfA, ovfB;
  logic [7:0]  ovfC;
  logic [2:0]  maxChA, maxChB, maxChC;

  vote_count_bank #(.WIDTH(4), .NUM_CH(6), .LAT(2), .SATURATE(1)) dutA (
    .clk(clk), .rst_n(rstN), .inc_vld(incVld), .inc_ch(incCh), .inc_amt(incAmt[3:0]),
    .set_vld(setVld), .set_ch(setCh), .set_val(setVal[3:0]), .clear_all(clearAll),
    .rd_vld(rdVld), .rd_ch(rdCh), .rd_data(rdDataA), .rd_data_vld(rdVldA),
    .ovf(ovfA), .max_ch(maxChA), .max_val(maxValA));

  vote_count_bank #(.WIDTH(4), .NUM_CH(6), .LAT(3), .SATURATE(0)) dutB (
    .clk(clk), .rst_n(rstN), .inc_vld(incVld), .inc_ch(incCh), .inc_amt(incAmt[3:0]),
    .set_vld(setVld), .set_ch(setCh), .set_val(setVal[3:0]), .clear_all(clearAll),
    .rd_vld(rdVld), .rd_ch(rdCh), .rd_data(rdDataB), .rd_data_vld(rdVldB),
    .ovf(ovfB), .max_ch(maxChB), .max_val(maxValB));

  vote_count_bank #(.WIDTH(13), .NUM_CH(8), .LAT(1), .SATURATE(1)) dutC (
    .clk(clk), .rst_n(rstN), .inc_vld(incVld), .inc_ch(incCh), .inc_amt(incAmt),
    .set_vld(setVld), .set_ch(setCh), .set_val(setVal), .clear_all(clearAll),
    .rd_vld(rdVld), .rd_ch(rdCh), .rd_data(rdDataC), .rd_data_vld(rdVldC),
    .ovf(ovfC), .max_ch(maxChC), .max_val(maxValC));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int nChecks = 0;
  int nFails  = 0;

  int wP [ND];
  int nP [ND];
  int lP [ND];
  int sP [ND];

  logic [63:0] mCnt [ND][8];
  logic        mOvf [ND][8];
  logic        hV   [ND][8];
  logic [63:0] hD   [ND][8];
  logic [63:0] eRd     [ND];
  logic        eRdV    [ND];
  logic [63:0] eMaxCh  [ND];
  logic [63:0] eMaxVal [ND];

  typedef struct {
    logic        setV;
    logic [2:0]  setC;
    logic [12:0] setD;
    logic        incV;
    logic [2:0]  incC;
    logic [12:0] incA;
    logic        clr;
    logic [2:0]  rdC;
    logic [3:0]  expA;
    logic [3:0]  expB;
    logic [5:0]  expOvf;
  } vecT;

  vecT vec [10];

  task automatic checkValue(input string name, input logic [63:0] act, input logic [63:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: counters are plain integers, overflow is "sum exceeds the
  // largest WIDTH-bit value", and reads are a history of requests LAT edges deep.
  task automatic modelEdge();
    logic [63:0] lim, amt, sv, top, rv, s;
    int topCh;
    for (int d = 0; d < ND; d++) begin
      lim = (64'd1 << wP[d]) - 64'd1;
      if (!rstN) begin
        for (int c = 0; c < 8; c++) begin
          mCnt[d][c] = '0; mOvf[d][c] = 1'b0; hV[d][c] = 1'b0; hD[d][c] = '0;
        end
        eRd[d] = '0; eRdV[d] = 1'b0; eMaxCh[d] = '0; eMaxVal[d] = '0;
      end else begin
        top = '0;
        for (int c = 0; c < nP[d]; c++) if (mCnt[d][c] > top) top = mCnt[d][c];
        topCh = 0;
        for (int c = nP[d] - 1; c >= 0; c--) if (mCnt[d][c] == top) topCh = c;
        rv = (int'(rdCh) < nP[d]) ? mCnt[d][rdCh] : 64'd0;
        for (int k = 7; k > 0; k--) begin
          hV[d][k] = hV[d][k-1];
          hD[d][k] = hD[d][k-1];
        end
        hV[d][0] = rdVld;
        hD[d][0] = rv;
        eRdV[d] = hV[d][lP[d]-1];
        if (eRdV[d]) eRd[d] = hD[d][lP[d]-1];
        amt = 64'(incAmt) & lim;
        sv  = 64'(setVal) & lim;
        for (int c = 0; c < nP[d]; c++) begin
          if (clearAll) begin
            mCnt[d][c] = '0; mOvf[d][c] = 1'b0;
          end else if (setVld && int'(setCh) == c) begin
            mCnt[d][c] = sv; mOvf[d][c] = 1'b0;
          end else if (incVld && int'(incCh) == c) begin
            s = mCnt[d][c] + amt;
            if (s > lim) begin
              mOvf[d][c] = 1'b1;
              mCnt[d][c] = (sP[d] != 0) ? lim : s - lim - 64'd1;
            end else begin
              mCnt[d][c] = s;
            end
          end
        end
        eMaxCh[d]  = 64'(topCh);
        eMaxVal[d] = top;
      end
    end
  endtask

  task automatic checkOutput();
    logic [63:0] aRd [ND];
    logic [63:0] aV  [ND];
    logic [63:0] aOv [ND];
    logic [63:0] aMc [ND];
    logic [63:0] aMv [ND];
    logic [63:0] eo;
    aRd[0] = 64'(rdDataA); aV[0] = 64'(rdVldA); aOv[0] = 64'(ovfA); aMc[0] = 64'(maxChA); aMv[0] = 64'(maxValA);
    aRd[1] = 64'(rdDataB); aV[1] = 64'(rdVldB); aOv[1] = 64'(ovfB); aMc[1] = 64'(maxChB); aMv[1] = 64'(maxValB);
    aRd[2] = 64'(rdDataC); aV[2] = 64'(rdVldC); aOv[2] = 64'(ovfC); aMc[2] = 64'(maxChC); aMv[2] = 64'(maxValC);
    for (int d = 0; d < ND; d++) begin
      eo = '0;
      for (int c = 0; c < nP[d]; c++) eo[c] = mOvf[d][c];
      checkValue($sformatf("dut%0d rd_data_vld", d), aV[d], 64'(eRdV[d]));
      checkValue($sformatf("dut%0d rd_data", d), aRd[d], eRd[d]);
      checkValue($sformatf("dut%0d ovf", d), aOv[d], eo);
      checkValue($sformatf("dut%0d max_ch", d), aMc[d], eMaxCh[d]);
      checkValue($sformatf("dut%0d max_val", d), aMv[d], eMaxVal[d]);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    modelEdge();
    #1;
    checkOutput();
  endtask

  task automatic idleInputs();
    incVld = 1'b0; setVld = 1'b0; clearAll = 1'b0; rdVld = 1'b0;
    incCh = '0; setCh = '0; rdCh = '0; incAmt = '0; setVal = '0;
  endtask

  // One operation cycle, then a read of the row's channel, then enough idle
  // cycles for the slowest read latency before comparing the held rd_data.
  task automatic applyStimulus(input vecT v, input int idx);
    setVld = v.setV; setCh = v.setC; setVal = v.setD;
    incVld = v.incV; incCh = v.incC; incAmt = v.incA;
    clearAll = v.clr;
    tick();
    idleInputs();
    rdVld = 1'b1; rdCh = v.rdC;
    tick();
    rdVld = 1'b0;
    repeat (3) tick();
    checkValue($sformatf("vec%0d A rd_data", idx), 64'(rdDataA), 64'(v.expA));
    checkValue($sformatf("vec%0d B rd_data", idx), 64'(rdDataB), 64'(v.expB));
    checkValue($sformatf("vec%0d A ovf", idx), 64'(ovfA), 64'(v.expOvf));
    checkValue($sformatf("vec%0d B ovf", idx), 64'(ovfB), 64'(v.expOvf));
  endtask

  initial begin
    wP = '{4, 4, 13};
    nP = '{6, 6, 8};
    lP = '{2, 3, 1};
    sP = '{1, 0, 1};

    //            setV  setC  setD    incV  incC  incA   clr   rdC   expA   expB   expOvf
    vec[0] = '{1'b0, 3'd0, 13'd0,  1'b0, 3'd0, 13'd0, 1'b1, 3'd0, 4'd0,  4'd0,  6'b000000};
    vec[1] = '{1'b1, 3'd0, 13'd14, 1'b0, 3'd0, 13'd0, 1'b0, 3'd0, 4'd14, 4'd14, 6'b000000};
    vec[2] = '{1'b0, 3'd0, 13'd0,  1'b1, 3'd0, 13'd3, 1'b0, 3'd0, 4'd15, 4'd1,  6'b000001};
    vec[3] = '{1'b1, 3'd0, 13'd2,  1'b0, 3'd0, 13'd0, 1'b0, 3'd0, 4'd2,  4'd2,  6'b000000};
    vec[4] = '{1'b1, 3'd2, 13'd9,  1'b1, 3'd2, 13'd4, 1'b0, 3'd2, 4'd9,  4'd9,  6'b000000};
    vec[5] = '{1'b1, 3'd1, 13'd9,  1'b1, 3'd5, 13'd4, 1'b0, 3'd1, 4'd9,  4'd9,  6'b000000};
    vec[6] = '{1'b0, 3'd0, 13'd0,  1'b0, 3'd0, 13'd0, 1'b0, 3'd5, 4'd4,  4'd4,  6'b000000};
    vec[7] = '{1'b1, 3'd7, 13'd5,  1'b0, 3'd0, 13'd0, 1'b0, 3'd7, 4'd0,  4'd0,  6'b000000};
    vec[8] = '{1'b0, 3'd0, 13'd0,  1'b1, 3'd7, 13'd3, 1'b0, 3'd6, 4'd0,  4'd0,  6'b000000};
    vec[9] = '{1'b1, 3'd3, 13'd7,  1'b0, 3'd0, 13'd0, 1'b1, 3'd3, 4'd0,  4'd0,  6'b000000};

    idleInputs();
    rstN = 1'b0;
    repeat (2) tick();
    rstN = 1'b1;
    tick();

    for (int i = 0; i < 10; i++) applyStimulus(vec[i], i);

    $display("[TB] basic accumulate");
    clearAll = 1'b1; tick(); clearAll = 1'b0;
    incVld = 1'b1; incCh = 3'd3; incAmt = 13'd1;
    repeat (5) tick();
    incCh = 3'd5; incAmt = 13'd7;
    tick();
    incVld = 1'b0;
    rdVld = 1'b1; rdCh = 3'd3;
    tick();
    checkValue("acc C ch3 after 1", 64'(rdDataC), 64'd5);
    rdCh = 3'd5;
    tick();
    checkValue("acc A ch3 vld after 2", 64'(rdVldA), 64'd1);
    checkValue("acc A ch3 data after 2", 64'(rdDataA), 64'd5);
    rdVld = 1'b0;
    tick();
    checkValue("acc A ch5 data", 64'(rdDataA), 64'd7);
    checkValue("acc A max_ch", 64'(maxChA), 64'd5);
    checkValue("acc A max_val", 64'(maxValA), 64'd7);
    checkValue("acc C max_ch", 64'(maxChC), 64'd5);

    $display("[TB] read-before-write");
    setVld = 1'b1; setCh = 3'd4; setVal = 13'd10;
    tick();
    setVld = 1'b0;
    incVld = 1'b1; incCh = 3'd4; incAmt = 13'd1; rdVld = 1'b1; rdCh = 3'd4;
    tick();
    incVld = 1'b0;
    tick();
    checkValue("rbw A first vld", 64'(rdVldA), 64'd1);
    checkValue("rbw A first data", 64'(rdDataA), 64'd10);
    rdVld = 1'b0;
    tick();
    checkValue("rbw A second vld", 64'(rdVldA), 64'd1);
    checkValue("rbw A second data", 64'(rdDataA), 64'd11);
    checkValue("rbw B first data", 64'(rdDataB), 64'd10);
    tick();
    checkValue("rbw B second vld", 64'(rdVldB), 64'd1);
    checkValue("rbw B second data", 64'(rdDataB), 64'd11);

    $display("[TB] argmax tie");
    clearAll = 1'b1; tick(); clearAll = 1'b0;
    setVld = 1'b1; setCh = 3'd1; setVal = 13'd8; tick();
    setCh = 3'd4; tick();
    setVld = 1'b0;
    repeat (2) tick();
    checkValue("tie A max_ch", 64'(maxChA), 64'd1);
    checkValue("tie A max_val", 64'(maxValA), 64'd8);
    checkValue("tie C max_ch", 64'(maxChC), 64'd1);

    $display("[TB] reset with reads in flight");
    rdVld = 1'b1; rdCh = 3'd1; tick();
    rdCh = 3'd4; tick();
    rdVld = 1'b0; rstN = 1'b0;
    tick();
    checkValue("rst A rd_data", 64'(rdDataA), 64'd0);
    checkValue("rst B rd_data_vld", 64'(rdVldB), 64'd0);
    checkValue("rst A max_val", 64'(maxValA), 64'd0);
    rstN = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checkValue("post-rst B rd_data_vld", 64'(rdVldB), 64'd0);
    end
    for (int c = 0; c < 6; c++) begin
      rdVld = 1'b1; rdCh = 3'(c); tick();
      rdVld = 1'b0; repeat (3) tick();
      checkValue($sformatf("post-rst B ch%0d", c), 64'(rdDataB), 64'd0);
    end

    $display("[TB] random traffic");
    for (int n = 0; n < 1500; n++) begin
      rstN     = ($urandom_range(0, 199) != 0);
      clearAll = ($urandom_range(0, 59) == 0);
      setVld   = ($urandom_range(0, 5) == 0);
      setCh    = 3'($urandom_range(0, 7));
      setVal   = 13'($urandom);
      incVld   = ($urandom_range(0, 1) == 0);
      incCh    = 3'($urandom_range(0, 7));
      incAmt   = ($urandom_range(0, 3) == 0) ? 13'($urandom) : 13'($urandom_range(0, 5));
      rdVld    = ($urandom_range(0, 1) == 0);
      rdCh     = 3'($urandom_range(0, 7));
      tick();
    end
    rstN = 1'b1;
    idleInputs();
    repeat (4) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
